buffer_read_controller: RTL and testbench

BUFFER_READ_CONTROLLER -- requirements
Module: buffer_read_controller

---
 rtl/domdup_pkg.sv | 23 ++
 rtl/test_pattern_gen.sv | 48 ++++
 rtl/buffer_read_controller.sv | 167 ++++++++++++++++
 tb/tb_buffer_read_controller.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/domdup_pkg.sv
// ----------------------------------------------------------------------------
// domdup_pkg
// Shared definitions for the ping-pong buffer read path: read FSM state
// encoding, default burst length and datapath widths.
// ----------------------------------------------------------------------------
package domdup_pkg;

    // One full half-buffer per burst.
    localparam int unsigned BURST_WORDS_DEFAULT = 8192;

    localparam int unsigned WORD_CNT_W  = 14;
    localparam int unsigned BUF_DATA_W  = 10;
    localparam int unsigned HOST_DATA_W = 16;
    localparam int unsigned BURST_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BURST  = 2'd1,
        DRAIN1 = 2'd2,
        DRAIN2 = 2'd3
    } rd_state_e;

endpackage : domdup_pkg

// File: rtl/test_pattern_gen.sv
// ----------------------------------------------------------------------------
// test_pattern_gen
// Free-running 10-bit word counter that stands in for buffer data when the
// build defines TEST_PATTERN_EN. The module only exists in that build.
//
// Ports:
//   clk        buffer read clock, rising edge
//   rst_n      asynchronous active-low reset
//   advance_i  a word is being handed to the host this edge
//   clear_i    restart the sequence at 0 (wins over advance_i)
//   pattern_o  value for the word currently being handed over
// ----------------------------------------------------------------------------
`ifdef TEST_PATTERN_EN
module test_pattern_gen
    import domdup_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  advance_i,
    input  logic                  clear_i,
    output logic [BUF_DATA_W-1:0] pattern_o
);

    logic [BUF_DATA_W-1:0] pattern_q;
    logic [BUF_DATA_W-1:0] pattern_d;

    always_comb begin
        pattern_d = pattern_q;
        if (clear_i) begin
            pattern_d = '0;
        end else if (advance_i) begin
            // Natural wrap 1023 -> 0.
            pattern_d = pattern_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pattern_q <= '0;
        end else begin
            pattern_q <= pattern_d;
        end
    end

    assign pattern_o = pattern_q;

endmodule : test_pattern_gen
`endif

// File: rtl/buffer_read_controller.sv
// ----------------------------------------------------------------------------
// buffer_read_controller
// Reads one full half-buffer (BURST_WORDS words) out of the ping-pong buffer
// whenever the host enables capture and a half-buffer is ready, and forwards
// each word to the FX3 GPIF host interface. Reads are only issued when the
// host can take a word, so no back-pressure FIFO is needed: the two-cycle
// buffer-read/register pipeline always has room.
//
// Build option: define TEST_PATTERN_EN to replace buffer data with a 10-bit
// incrementing test pattern (sub-module test_pattern_gen).
//
// Ports:
//   readClock        sole clock, rising edge
//   nReset           asynchronous active-low reset
//   collectData      host capture enable
//   dataAvailable    a full half-buffer is readable
//   bufferOverflow   write-side overflow flag
//   bufferData       read data, valid one clock after isReading
//   hostReady        host can accept a word this cycle
//   isReading        buffer read request (combinational in BURST)
//   hostData         word to host, {6'b0, data}
//   hostDataValid    hostData qualifier, two clocks after isReading
//   endOfBurst       marks the final word of a burst
//   overflowLatched  sticky overflow indication
//   burstCount       completed bursts since collectData rose
// ----------------------------------------------------------------------------
module buffer_read_controller
    import domdup_pkg::*;
#(
    parameter int unsigned BURST_WORDS = BURST_WORDS_DEFAULT
)
(
    input  logic                   readClock,
    input  logic                   nReset,
    input  logic                   collectData,
    input  logic                   dataAvailable,
    input  logic                   bufferOverflow,
    input  logic [BUF_DATA_W-1:0]  bufferData,
    input  logic                   hostReady,
    output logic                   isReading,
    output logic [HOST_DATA_W-1:0] hostData,
    output logic                   hostDataValid,
    output logic                   endOfBurst,
    output logic                   overflowLatched,
    output logic [BURST_CNT_W-1:0] burstCount
);

    localparam logic [WORD_CNT_W-1:0] LAST_WORD = WORD_CNT_W'(BURST_WORDS - 1);

    rd_state_e               state_q,      state_d;
    logic [WORD_CNT_W-1:0]   word_cnt_q,   word_cnt_d;
    logic                    rd_q;          // read issued last cycle: bufferData valid now
    logic                    valid_q,      valid_d;
    logic [HOST_DATA_W-1:0]  data_q,       data_d;
    logic                    ovf_q,        ovf_d;
    logic [BURST_CNT_W-1:0]  burst_cnt_q,  burst_cnt_d;
    logic                    rd_req;
    logic [BUF_DATA_W-1:0]   word_src;

    // ------------------------------------------------------------------
    // Read FSM: next state, word counter and read request
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case leaves a signal unassigned and no latch is built.
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        rd_req     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (collectData && dataAvailable) begin
                    state_d = BURST;
                end
            end
            BURST: begin
                // collectData and dataAvailable are deliberately not looked
                // at here: a started burst always empties its half-buffer.
                rd_req = hostReady;
                if (hostReady) begin
                    if (word_cnt_q == LAST_WORD) begin
                        word_cnt_d = '0;
                        state_d    = DRAIN1;
                    end else begin
                        word_cnt_d = word_cnt_q + 1'b1;
                    end
                end
            end
            DRAIN1: state_d = DRAIN2;  // last word is in the buffer read stage
            DRAIN2: state_d = IDLE;    // last word is on hostData
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Status and output datapath
    // ------------------------------------------------------------------
`ifdef TEST_PATTERN_EN
    test_pattern_gen u_test_pattern_gen (
        .clk       (readClock),
        .rst_n     (nReset),
        .advance_i (rd_q),
        .clear_i   (!collectData),
        .pattern_o (word_src)
    );
`else
    assign word_src = bufferData;
`endif

    always_comb begin
        valid_d = rd_q;
        data_d  = rd_q ? {{(HOST_DATA_W - BUF_DATA_W){1'b0}}, word_src} : data_q;

        // Set wins over clear so an overflow seen while capture is being
        // disabled is still reported for that cycle.
        if (bufferOverflow) begin
            ovf_d = 1'b1;
        end else if (!collectData) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end

        if (!collectData) begin
            burst_cnt_d = '0;
        end else if (state_q == DRAIN2) begin
            burst_cnt_d = burst_cnt_q + 1'b1;
        end else begin
            burst_cnt_d = burst_cnt_q;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge readClock or negedge nReset) begin
        // NOTE: the reset clears the whole pipeline, including rd_q, so a
        // word in flight at reset is dropped rather than delivered later.
        if (!nReset) begin
            state_q     <= IDLE;
            word_cnt_q  <= '0;
            rd_q        <= 1'b0;
            valid_q     <= 1'b0;
            data_q      <= '0;
            ovf_q       <= 1'b0;
            burst_cnt_q <= '0;
        end else begin
            // NOTE: non-blocking assignments here, so every register samples
            // the values from before this edge regardless of statement order.
            state_q     <= state_d;
            word_cnt_q  <= word_cnt_d;
            rd_q        <= rd_req;
            valid_q     <= valid_d;
            data_q      <= data_d;
            ovf_q       <= ovf_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    assign isReading       = rd_req;
    assign hostData        = data_q;
    assign hostDataValid   = valid_q;
    assign endOfBurst      = (state_q == DRAIN2);
    assign overflowLatched = ovf_q;
    assign burstCount      = burst_cnt_q;

endmodule : buffer_read_controller

// File: tb/tb_buffer_read_controller.sv
// ----------------------------------------------------------------------------
// tb_buffer_read_controller
// Self-checking bench. A behavioural model tracks the burst as a word count
// plus a drain countdown; a buffer model returns a random word one clock
// after each read and queues it as the expected host word. Outputs are
// sampled on the falling edge; inputs change 1 ns after the rising edge.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_buffer_read_controller;

    localparam int BW = 8192;

    logic        readClock = 1'b0;
    logic        nReset;
    logic        collectData;
    logic        dataAvailable;
    logic        bufferOverflow;
    logic [9:0]  bufferData;
    logic        hostReady;
    logic        isReading;
    logic [15:0] hostData;
    logic        hostDataValid;
    logic        endOfBurst;
    logic        overflowLatched;
    logic [15:0] burstCount;

    buffer_read_controller dut (
        .readClock       (readClock),
        .nReset          (nReset),
        .collectData     (collectData),
        .dataAvailable   (dataAvailable),
        .bufferOverflow  (bufferOverflow),
        .bufferData      (bufferData),
        .hostReady       (hostReady),
        .isReading       (isReading),
        .hostData        (hostData),
        .hostDataValid   (hostDataValid),
        .endOfBurst      (endOfBurst),
        .overflowLatched (overflowLatched),
        .burstCount      (burstCount)
    );

    always #5 readClock = ~readClock;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model state
    // ------------------------------------------------------------------
    bit          m_active;      // a burst is in progress
    int          m_words;       // words read so far in this burst
    int          m_drain;       // 2,1 = drain cycles left after last read
    int          m_bursts;      // expected burstCount
    bit          m_ovf;
    bit          m_d1, m_d2;    // expected reads one and two cycles ago
    logic [15:0] exp_q[$];      // expected host words in order
    logic [9:0]  m_pat;         // test pattern model
    logic [9:0]  m_pat_data;

    int          words_issued  = 0;
    int          eob_seen      = 0;
    int          valid_in_burst = 0;
    bit          pend_vld = 1'b0;
    logic [9:0]  pend_data;

    task automatic model_reset();
        m_active = 0; m_words = 0; m_drain = 0; m_bursts = 0; m_ovf = 0;
        m_d1 = 0; m_d2 = 0; m_pat = '0; m_pat_data = '0;
        exp_q.delete();
        pend_vld = 0;
        valid_in_burst = 0;
    endtask

    // Buffer model: the word for a read appears 1 ns after the following
    // rising edge and holds for one cycle; otherwise the bus carries noise.
    always @(posedge readClock) begin
        #1;
        if (pend_vld) begin
            bufferData = pend_data;
            pend_vld   = 0;
        end else begin
            bufferData = 10'($urandom);
        end
    end

    // Output checker and model update, once per cycle.
    always @(negedge readClock) begin
        bit          exp_rd;
        bit          na;
        int          nw, nd;
        logic [15:0] e;
        if (!nReset) begin
            check("rst_isReading", isReading, 0);
            check("rst_valid", hostDataValid, 0);
            check("rst_hostData", hostData, 0);
            check("rst_eob", endOfBurst, 0);
            check("rst_ovf", overflowLatched, 0);
            check("rst_burstCount", burstCount, 0);
            model_reset();
        end else begin
            exp_rd = m_active && hostReady;
            check("isReading", isReading, exp_rd);
            check("hostDataValid", hostDataValid, m_d2);
            check("endOfBurst", endOfBurst, m_drain == 1);
            check("overflowLatched", overflowLatched, m_ovf);
            check("burstCount", burstCount, m_bursts);

            if (hostDataValid) begin
`ifdef TEST_PATTERN_EN
                check("pattern", hostData, {6'b0, m_pat_data});
`else
                if (exp_q.size() == 0) begin
                    check("data_underrun", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("hostData", hostData, e);
                end
`endif
                valid_in_burst++;
            end
            if (endOfBurst) begin
                check("burst_len", valid_in_burst, BW);
                valid_in_burst = 0;
                eob_seen++;
            end
            if (isReading) begin
                words_issued++;
                pend_data = 10'($urandom);
                pend_vld  = 1;
`ifndef TEST_PATTERN_EN
                exp_q.push_back({6'b0, pend_data});
`endif
            end

            // Advance the model to the next cycle.
`ifdef TEST_PATTERN_EN
            if (m_d1) m_pat_data = m_pat;
            if (!collectData) m_pat = '0;
            else if (m_d1) m_pat = m_pat + 1'b1;
`endif
            if (bufferOverflow) m_ovf = 1;
            else if (!collectData) m_ovf = 0;

            if (!collectData) m_bursts = 0;
            else if (m_drain == 1) m_bursts = (m_bursts + 1) % 65536;

            na = m_active; nw = m_words; nd = m_drain;
            if (m_active && hostReady) begin
                nw = m_words + 1;
                if (nw == BW) begin
                    na = 0; nw = 0; nd = 2;
                end
            end else if (m_drain > 0) begin
                nd = m_drain - 1;
            end else if (!m_active && collectData && dataAvailable) begin
                na = 1;
            end
            m_active = na; m_words = nw; m_drain = nd;
            m_d2 = m_d1;
            m_d1 = exp_rd;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge readClock);
        #1;
    endtask

    task automatic wait_words(input int target, input int budget);
        int n = 0;
        while (words_issued < target && n < budget) begin
            tick();
            n++;
        end
        check("wait_words_bound", words_issued >= target, 1);
    endtask

    task automatic wait_eob(input int target, input int budget);
        int n = 0;
        while (eob_seen < target && n < budget) begin
            tick();
            n++;
        end
        check("wait_eob_bound", eob_seen >= target, 1);
    endtask

    task automatic start_burst();
        dataAvailable = 1;
        tick();
        dataAvailable = 0;
    endtask

    initial begin
        #(80000 * 10);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  base;
        int  n;
        bit  held;
        bit  ovf_done;

        nReset = 0; collectData = 0; dataAvailable = 0;
        bufferOverflow = 0; hostReady = 0; bufferData = '0;
        model_reset();
        repeat (3) tick();
        nReset = 1;
        tick();

        // Burst 1: everything held high; dataAvailable drops mid-burst.
        collectData = 1; dataAvailable = 1; hostReady = 1;
        base = words_issued;
        wait_words(base + 10, 100);
        dataAvailable = 0;
        wait_eob(1, BW + 100);
        repeat (3) tick();
        check("burst1_words", words_issued - base, BW);
        check("burst1_count", burstCount, 1);
        check("burst1_idle_read", isReading, 0);

        // Burst 2: random host back-pressure, a 10-cycle stall after word
        // 100 and a one-cycle overflow pulse mid-burst.
        base = words_issued;
        start_burst();
        held = 0; ovf_done = 0; n = 0;
        while (eob_seen < 2 && n < 30000) begin
            if (!held && words_issued >= base + 100) begin
                hostReady = 0;
                repeat (10) begin
                    tick();
                    check("stall_no_read", isReading, 0);
                end
                n += 10;
                held = 1;
            end
            hostReady = ($urandom_range(0, 3) != 0);
            bufferOverflow = (!ovf_done && words_issued >= base + 3000);
            if (bufferOverflow) ovf_done = 1;
            tick();
            n++;
        end
        bufferOverflow = 0;
        hostReady = 1;
        check("burst2_done", eob_seen, 2);
        repeat (3) tick();
        check("burst2_words", words_issued - base, BW);
        check("ovf_sticky", overflowLatched, 1);
        check("burst2_count", burstCount, 2);

        // Burst 3: collectData drops at word 4000; burst must still finish.
        base = words_issued;
        start_burst();
        wait_words(base + 4000, 5000);
        collectData = 0;
        tick();
        check("ovf_cleared", overflowLatched, 0);
        wait_eob(3, BW + 100);
        repeat (3) tick();
        check("burst3_words", words_issued - base, BW);
        check("burst3_count_clear", burstCount, 0);
        dataAvailable = 1;
        repeat (20) tick();
        check("no_start_without_collect", words_issued - base, BW);
        dataAvailable = 0;
        collectData = 1;
        tick();

        // Burst 4: reset asserted at word 5000.
        base = words_issued;
        start_burst();
        wait_words(base + 5000, 6000);
        nReset = 0;
        #1;
        check("rst_async_valid", hostDataValid, 0);
        check("rst_async_read", isReading, 0);
        repeat (3) tick();
        nReset = 1;
        n = words_issued;
        repeat (20) tick();
        check("post_rst_no_read", words_issued, n);
        check("post_rst_valid", hostDataValid, 0);
        check("post_rst_count", burstCount, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_buffer_read_controller
